sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 158 +++++++++++++++
 tb/tb_sram_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Behavioural model of an asynchronous 16-bit SRAM seen from a controller:
// read latency tracking, minimum-width write commit, byte lanes, and protocol error pulses.
module sram_responder #(
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 2,
  parameter int WR_MIN = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [19:0] i_SRAM_ADDR,
  input  logic        i_SRAM_WE_N,
  input  logic        i_SRAM_CE_N,
  input  logic        i_SRAM_OE_N,
  input  logic        i_SRAM_LB_N,
  input  logic        i_SRAM_UB_N,
  inout  wire  [15:0] io_SRAM_DQ,
  output logic [15:0] o_wr_cnt,
  output logic [15:0] o_rd_cnt,
  output logic        o_err_short_wr,
  output logic        o_err_addr_chg
);

  localparam int         DEPTH     = 1 << MEM_AW;
  localparam logic [3:0] RD_LAT_L  = 4'(RD_LAT);
  localparam logic [3:0] RD_LAT_M1 = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_MIN_L  = 4'(WR_MIN);

  typedef enum logic [1:0] {RD_IDLE, RD_SETTLE, RD_VALID} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_COMMIT} wr_state_t;

  logic [15:0]       mem [DEPTH];

  rd_state_t         rd_state_reg;
  wr_state_t         wr_state_reg;
  logic [MEM_AW-1:0] addr;
  logic [MEM_AW-1:0] addr_prev_reg;
  logic [3:0]        lat_cnt_reg;
  logic [15:0]       dout_reg;

  logic [MEM_AW-1:0] cap_addr_reg;
  logic [15:0]       cap_data_reg;
  logic [1:0]        cap_be_n_reg;
  logic [3:0]        wr_len_reg;

  logic              rd_en;
  logic              wr_low;
  logic              rd_step;
  logic              rd_first;
  logic              rd_load;
  logic              commit_ok;
  logic [1:0]        lane_we;

  assign addr      = i_SRAM_ADDR[MEM_AW-1:0];
  assign rd_en     = ~i_SRAM_CE_N & ~i_SRAM_OE_N & i_SRAM_WE_N;
  assign wr_low    = ~i_SRAM_CE_N & ~i_SRAM_WE_N;
  assign rd_step   = rd_en && (addr == addr_prev_reg);
  assign rd_first  = rd_step && (rd_state_reg != RD_VALID) && (lat_cnt_reg == RD_LAT_M1);
  assign rd_load   = rd_step && ((rd_state_reg == RD_VALID) || rd_first);
  assign commit_ok = (wr_state_reg == WR_COMMIT) && (wr_len_reg >= WR_MIN_L);

  // The bus is released while reset is held even if the strobes request a read.
  assign io_SRAM_DQ = (rd_en && i_rst) ? dout_reg : 16'bz;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_we[gi] = commit_ok & ~cap_be_n_reg[gi];
    end
    if (MEM_AW < 20) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = |i_SRAM_ADDR[19:MEM_AW];
    end
  endgenerate

  // Array is never reset; both lanes off still counts as a commit but writes nothing.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 2; b++) begin
      if (lane_we[b]) mem[cap_addr_reg][b*8 +: 8] <= cap_data_reg[b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_state_reg  <= RD_IDLE;
      addr_prev_reg <= '0;
      lat_cnt_reg   <= '0;
      dout_reg      <= 16'h0000;
      o_rd_cnt      <= 16'h0000;
    end else begin
      addr_prev_reg <= addr;
      if (!rd_step) begin
        lat_cnt_reg  <= '0;
        rd_state_reg <= rd_en ? RD_SETTLE : RD_IDLE;
      end else if (lat_cnt_reg < RD_LAT_L) begin
        lat_cnt_reg  <= lat_cnt_reg + 4'd1;
        rd_state_reg <= rd_first ? RD_VALID : RD_SETTLE;
      end
      // Stale data stays on the bus until the window matures, then tracks the array.
      if (rd_load) dout_reg <= mem[addr];
      if (rd_first) o_rd_cnt <= o_rd_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_state_reg   <= WR_IDLE;
      wr_len_reg     <= '0;
      cap_addr_reg   <= '0;
      cap_data_reg   <= 16'h0000;
      cap_be_n_reg   <= 2'b11;
      o_wr_cnt       <= 16'h0000;
      o_err_short_wr <= 1'b0;
      o_err_addr_chg <= 1'b0;
    end else begin
      o_err_short_wr <= 1'b0;
      o_err_addr_chg <= 1'b0;
      case (wr_state_reg)
        WR_IDLE: begin
          if (wr_low) begin
            wr_state_reg <= WR_ACTIVE;
            wr_len_reg   <= 4'd1;
            cap_addr_reg <= addr;
            cap_data_reg <= io_SRAM_DQ;
            cap_be_n_reg <= {i_SRAM_UB_N, i_SRAM_LB_N};
          end
        end
        WR_ACTIVE: begin
          if (wr_low) begin
            wr_len_reg     <= (wr_len_reg == 4'hF) ? 4'hF : wr_len_reg + 4'd1;
            cap_addr_reg   <= addr;
            cap_data_reg   <= io_SRAM_DQ;
            cap_be_n_reg   <= {i_SRAM_UB_N, i_SRAM_LB_N};
            o_err_addr_chg <= (addr != cap_addr_reg);
          end else begin
            wr_state_reg <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          if (wr_len_reg >= WR_MIN_L) o_wr_cnt <= o_wr_cnt + 16'd1;
          else o_err_short_wr <= 1'b1;
          // A low strobe here is the first cycle of the next write, not a lost cycle.
          if (wr_low) begin
            wr_state_reg <= WR_ACTIVE;
            wr_len_reg   <= 4'd1;
            cap_addr_reg <= addr;
            cap_data_reg <= io_SRAM_DQ;
            cap_be_n_reg <= {i_SRAM_UB_N, i_SRAM_LB_N};
          end else begin
            wr_state_reg <= WR_IDLE;
            wr_len_reg   <= '0;
          end
        end
        default: wr_state_reg <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: reference array model plus a queue of expected read data.
module tb_sram_responder;
  localparam int MEM_AW = 10;
  localparam int RD_LAT = 2;
  localparam int WR_MIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] addr = '0;
  logic        we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1, lb_n = 1'b1, ub_n = 1'b1;
  logic [15:0] tb_dq_drv = 16'h0000;
  logic        tb_dq_en = 1'b0;
  wire  [15:0] dq;
  logic [15:0] o_wr_cnt, o_rd_cnt;
  logic        o_err_short_wr, o_err_addr_chg;

  assign dq = tb_dq_en ? tb_dq_drv : 16'bz;

  sram_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .WR_MIN(WR_MIN)) dut (
    .i_clk(clk), .i_rst(rst), .i_SRAM_ADDR(addr),
    .i_SRAM_WE_N(we_n), .i_SRAM_CE_N(ce_n), .i_SRAM_OE_N(oe_n),
    .i_SRAM_LB_N(lb_n), .i_SRAM_UB_N(ub_n), .io_SRAM_DQ(dq),
    .o_wr_cnt(o_wr_cnt), .o_rd_cnt(o_rd_cnt),
    .o_err_short_wr(o_err_short_wr), .o_err_addr_chg(o_err_addr_chg)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_fail = 0;
  int          short_pulses = 0, chg_pulses = 0;
  int          exp_wr = 0, exp_rd = 0, exp_short = 0, exp_chg = 0;
  logic [15:0] exp_q [$];
  logic [15:0] model_mem [int];
  logic [15:0] model_dout = 16'h0000;

  always @(posedge clk) begin
    if (o_err_short_wr === 1'b1) short_pulses++;
    if (o_err_addr_chg === 1'b1) chg_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the bus with a probe; a DUT driving at the same time corrupts it.
  task automatic hiz_check(input string tag, input logic [15:0] probe);
    tb_dq_drv = probe;
    tb_dq_en  = 1'b1;
    #1;
    check(tag, 32'(dq), 32'(probe));
    tb_dq_en  = 1'b0;
    #1;
  endtask

  task automatic model_write(input logic [19:0] a, input logic [15:0] d, input logic lb, input logic ub);
    logic [15:0] w;
    int          k;
    k = int'(a[MEM_AW-1:0]);
    w = model_mem.exists(k) ? model_mem[k] : 16'h0000;
    if (!lb) w[7:0]  = d[7:0];
    if (!ub) w[15:8] = d[15:8];
    model_mem[k] = w;
  endtask

  task automatic post_write_checks();
    repeat (3) tick();
    check("wr_cnt", 32'(o_wr_cnt), exp_wr);
    check("short_pulses", short_pulses, exp_short);
    check("addr_chg_pulses", chg_pulses, exp_chg);
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic lb, input logic ub, input int n);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = a;
    tb_dq_drv = d; tb_dq_en = 1'b1; lb_n = lb; ub_n = ub;
    repeat (n) tick();
    we_n = 1'b1; tb_dq_en = 1'b0; lb_n = 1'b1; ub_n = 1'b1;
    if (n >= WR_MIN) begin
      model_write(a, d, lb, ub);
      exp_wr++;
    end else begin
      exp_short++;
    end
    $display("write addr=%h data=%h lb_n=%b ub_n=%b low_cycles=%0d", a, d, lb, ub, n);
    post_write_checks();
  endtask

  task automatic do_read(input logic [19:0] a);
    logic [15:0] e;
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b1; addr = a;
    tick();
    exp_q.push_back(model_mem[int'(a[MEM_AW-1:0])]);
    oe_n = 1'b0;
    #1;
    for (int i = 0; i < RD_LAT; i++) begin
      check("rd_stale", 32'(dq), 32'(model_dout));
      tick();
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $error("FAIL rd_queue: observed empty expected entry");
    end else begin
      e = exp_q.pop_front();
      check("rd_data", 32'(dq), 32'(e));
      model_dout = e;
    end
    exp_rd++;
    $display("read  addr=%h data=%h expected=%h", a, dq, model_dout);
    oe_n = 1'b1;
    tick();
    check("rd_cnt", 32'(o_rd_cnt), exp_rd);
    hiz_check("rd_release_hiz", 16'h0000);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_wr_cnt", 32'(o_wr_cnt), 0);
    check("rst_rd_cnt", 32'(o_rd_cnt), 0);
    check("rst_err_short", 32'(o_err_short_wr), 0);
    check("rst_err_chg", 32'(o_err_addr_chg), 0);
    hiz_check("rst_hiz", 16'h1357);
    rst = 1'b1;
    tick();

    do_write(20'h00012, 16'hA5C3, 1'b0, 1'b0, 8);
    do_read(20'h00012);

    do_write(20'h00012, 16'h1234, 1'b0, 1'b1, 5);
    do_read(20'h00012);

    do_write(20'h00012, 16'hFFFF, 1'b0, 1'b0, 3);
    do_read(20'h00012);

    do_write(20'h00055, 16'h0BEE, 1'b0, 1'b0, WR_MIN);
    do_read(20'h00055);

    do_read(20'h40012);

    // Address moves mid-write: the last low-cycle address and data win.
    ce_n = 1'b0; we_n = 1'b0; addr = 20'h00020; tb_dq_drv = 16'h1111; tb_dq_en = 1'b1;
    lb_n = 1'b0; ub_n = 1'b0;
    repeat (3) tick();
    addr = 20'h00021; tb_dq_drv = 16'h2222;
    repeat (3) tick();
    we_n = 1'b1; tb_dq_en = 1'b0; lb_n = 1'b1; ub_n = 1'b1;
    model_write(20'h00021, 16'h2222, 1'b0, 1'b0);
    exp_wr++; exp_chg++;
    $display("write addr=00020->00021 data=2222 low_cycles=6");
    post_write_checks();
    do_read(20'h00021);

    // Second write starts in the commit cycle of the first.
    ce_n = 1'b0; we_n = 1'b0; addr = 20'h00030; tb_dq_drv = 16'h3333; tb_dq_en = 1'b1;
    lb_n = 1'b0; ub_n = 1'b0;
    repeat (4) tick();
    we_n = 1'b1;
    tick();
    we_n = 1'b0; addr = 20'h00031; tb_dq_drv = 16'h4444;
    repeat (4) tick();
    we_n = 1'b1; tb_dq_en = 1'b0; lb_n = 1'b1; ub_n = 1'b1;
    model_write(20'h00030, 16'h3333, 1'b0, 1'b0);
    model_write(20'h00031, 16'h4444, 1'b0, 1'b0);
    exp_wr += 2;
    $display("write back-to-back 00030=3333 00031=4444");
    post_write_checks();
    do_read(20'h00031);
    do_read(20'h00030);

    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
    hiz_check("we_oe_overlap_hiz", 16'h0000);
    we_n = 1'b1; oe_n = 1'b1;

    // Reset during the fifth low cycle discards the pending write.
    ce_n = 1'b0; we_n = 1'b0; addr = 20'h00012; tb_dq_drv = 16'h0000; tb_dq_en = 1'b1;
    lb_n = 1'b0; ub_n = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    we_n = 1'b1; oe_n = 1'b0; tb_dq_en = 1'b0; lb_n = 1'b1; ub_n = 1'b1;
    #1;
    exp_wr = 0; exp_rd = 0; model_dout = 16'h0000;
    check("rst_mid_wr_cnt", 32'(o_wr_cnt), exp_wr);
    check("rst_mid_rd_cnt", 32'(o_rd_cnt), exp_rd);
    hiz_check("rst_mid_hiz", 16'h1357);
    oe_n = 1'b1;
    tick();
    rst = 1'b1;
    $display("reset during write addr=00012");
    post_write_checks();
    do_read(20'h00012);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
